// File: rtl/inbuf_rc_pkg.sv
// Shared constants and types for the input buffer / route computation block.
// Flit layout: [15:14] type, [13] multicast flag, [3:0] destination node.
package inbuf_rc_pkg;

    localparam int FLITW = 16;
    localparam int DSTW  = 4;
    localparam int MCBIT = 13;
    localparam int PORT  = 4;
    localparam int PORTW = 2;

    // Reset is asserted when rst_ equals this level.
    localparam logic Enable_ = 1'b0;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RC     = 2'b01,
        ST_ACTIVE = 2'b10
    } rc_state_e;

    function automatic flit_type_e flit_type(input logic [FLITW-1:0] f);
        return flit_type_e'(f[FLITW-1:FLITW-2]);
    endfunction

    // True for flits that open a packet (head or single).
    function automatic logic opens_pkt(input logic [FLITW-1:0] f);
        return (flit_type(f) == FT_HEAD) || (flit_type(f) == FT_SINGLE);
    endfunction

    // True for flits that close a packet (tail or single).
    function automatic logic closes_pkt(input logic [FLITW-1:0] f);
        return (flit_type(f) == FT_TAIL) || (flit_type(f) == FT_SINGLE);
    endfunction

endpackage

// File: rtl/inbuf_rc_fifo.sv
// ibuf_fifo: flit storage with wrapping pointers and occupancy count.
// Ports: clk, rst_ (sync, active-low), push/wdata in, pop in, rdata/full/empty out.
module ibuf_fifo
    import inbuf_rc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = FLITW
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ == Enable_) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inbuf_rc.sv
// inbuf_rc: input FIFO plus route computation (IDLE -> RC -> ACTIVE) and route table.
// Ports: idata/ivalid/iready upstream; tbl_* table write; port/req/multab/odata out; grt/multab_ct in.
module inbuf_rc
    import inbuf_rc_pkg::*;
#(
    parameter int PORTID = 0,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] idata,
    input  logic             ivalid,
    output logic             iready,
    input  logic             tbl_we,
    input  logic [DSTW-1:0]  tbl_addr,
    input  logic [PORTW:0]   tbl_data,
    output logic [PORTW:0]   port,
    output logic             req,
    output logic             multab,
    input  logic [PORT:0]    grt,
    input  logic [PORT:0]    multab_ct,
    output logic [FLITW-1:0] odata
);

    localparam int NTBL = 2 ** DSTW;
    localparam logic [PORTW:0] PID = (PORTW+1)'(PORTID);

    rc_state_e      state_q, state_d;
    logic [PORTW:0] port_q, port_d;
    logic           multab_q, multab_d;
    logic [PORTW:0] tbl_q [NTBL];
    logic [PORTW:0] tbl_d [NTBL];

    logic full, empty;
    logic push, pop, fwd_pop, drop_pop;

    assign iready = !full;
    assign push   = ivalid && !full;
    assign port   = port_q;
    assign multab = multab_q;
    assign req    = (state_q == ST_ACTIVE) && !empty;

    // Forward only when granted and no output reports contention.
    assign fwd_pop  = req && (|grt) && !(|multab_ct);
    // Orphan body/tail flits at the head while idle are discarded.
    assign drop_pop = (state_q == ST_IDLE) && !empty && !opens_pkt(odata);
    assign pop      = fwd_pop || drop_pop;

    ibuf_fifo #(
        .DEPTH (DEPTH),
        .W     (FLITW)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push),
        .pop   (pop),
        .wdata (idata),
        .rdata (odata),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        multab_d = multab_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && opens_pkt(odata)) begin
                    state_d = ST_RC;
                end
            end
            ST_RC: begin
                // Reads the table before any same-cycle write lands.
                port_d   = tbl_q[odata[DSTW-1:0]];
                multab_d = odata[MCBIT];
                state_d  = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (fwd_pop && closes_pkt(odata)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tbl_d = tbl_q;
        if (tbl_we) begin
            tbl_d[tbl_addr] = tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ == Enable_) begin
            state_q  <= ST_IDLE;
            port_q   <= '0;
            multab_q <= 1'b0;
            for (int i = 0; i < NTBL; i++) begin
                tbl_q[i] <= PID;
            end
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            multab_q <= multab_d;
            tbl_q    <= tbl_d;
        end
    end

endmodule
